// File: rtl/multi_counter_clock.sv
// -----------------------------------------------------------------------------
// multi_counter_clock
// Multi-channel, runtime-programmable clock divider. Each channel produces a
// registered divided clock with its own period and high time. New settings go
// into a per-channel shadow and are promoted to the active set only at the end
// of a period (or immediately while the channel is disabled), so outputs never
// show runt pulses.
//
// Optional feature macro: CLKDIV_SYNC_EN
//   When defined, adds sync_in. A pulse restarts every enabled channel at phase
//   0 (loading any pending shadow) so that channels can be phase-aligned.
//
// Ports
//   clk          in   1         system clock, all logic on posedge
//   rst          in   1         synchronous active-high reset
//   cfg_we       in   1         shadow write strobe
//   cfg_ch       in   CW        target channel (out-of-range indices ignored)
//   cfg_div      in   DIV_BITS  requested period in clk cycles
//   cfg_high     in   DIV_BITS  requested high time in clk cycles
//   ch_en        in   CHANNELS  per-channel run enable
//   sync_in      in   1         phase restart (CLKDIV_SYNC_EN only)
//   clk_out      out  CHANNELS  divided clocks
//   rise_tick    out  CHANNELS  strobe in the cycle clk_out goes 0->1
//   fall_tick    out  CHANNELS  strobe in the cycle clk_out goes 1->0
//   cfg_pending  out  CHANNELS  shadow written but not yet active
// -----------------------------------------------------------------------------
module multi_counter_clock #(
    parameter int CHANNELS    = 4,
    parameter int DIV_BITS    = 16,
    parameter int DEFAULT_DIV = 2,
    localparam int CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [CW-1:0]       cfg_ch,
    input  logic [DIV_BITS-1:0] cfg_div,
    input  logic [DIV_BITS-1:0] cfg_high,
    input  logic [CHANNELS-1:0] ch_en,
`ifdef CLKDIV_SYNC_EN
    input  logic                sync_in,
`endif
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] rise_tick,
    output logic [CHANNELS-1:0] fall_tick,
    output logic [CHANNELS-1:0] cfg_pending
);

    localparam logic [DIV_BITS-1:0] DIV_RST  = DIV_BITS'(DEFAULT_DIV);
    localparam logic [DIV_BITS-1:0] HIGH_RST = DIV_BITS'(DEFAULT_DIV / 2);
    localparam logic [DIV_BITS-1:0] ONE      = DIV_BITS'(1);
    localparam logic [DIV_BITS-1:0] TWO      = DIV_BITS'(2);

    // Periods below 2 cannot produce a high and a low phase, so clamp to 2.
    function automatic logic [DIV_BITS-1:0] eff_div(input logic [DIV_BITS-1:0] d);
        return (d < TWO) ? TWO : d;
    endfunction

    // Keep at least one low cycle per period.
    function automatic logic [DIV_BITS-1:0] eff_high(input logic [DIV_BITS-1:0] h,
                                                     input logic [DIV_BITS-1:0] de);
        return (h > de - ONE) ? de - ONE : h;
    endfunction

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [DIV_BITS-1:0] p_q, p_d;
        logic [DIV_BITS-1:0] div_q, div_d, high_q, high_d;
        logic [DIV_BITS-1:0] sdiv_q, sdiv_d, shigh_q, shigh_d;
        logic                pend_q, pend_d;
        logic                clk_q, clk_d, rise_q, rise_d, fall_q, fall_d;
        logic [DIV_BITS-1:0] div_eff, high_eff;
        logic                wr, wrap, load;

        always_comb begin
            wr       = cfg_we && (cfg_ch == CW'(i));
            div_eff  = eff_div(div_q);
            high_eff = eff_high(high_q, div_eff);
            wrap     = (p_q == div_eff - ONE);
            p_d      = p_q;
            div_d    = div_q;
            high_d   = high_q;
            sdiv_d   = sdiv_q;
            shigh_d  = shigh_q;
            pend_d   = pend_q;
            clk_d    = 1'b0;
            load     = 1'b0;

            if (!ch_en[i]) begin
                p_d   = '0;
                clk_d = 1'b0;
                load  = pend_q;
`ifdef CLKDIV_SYNC_EN
            end else if (sync_in) begin
                // Restart at phase 0 with the settings that will be active
                // after this edge; high_eff is zero only when high is zero.
                load  = pend_q;
                p_d   = '0;
                clk_d = (pend_q ? shigh_q : high_q) != '0;
`endif
            end else begin
                p_d   = wrap ? '0 : p_q + ONE;
                clk_d = (p_q < high_eff);
                load  = wrap && pend_q;
            end

            if (load) begin
                div_d  = sdiv_q;
                high_d = shigh_q;
                pend_d = 1'b0;
            end
            // A write on the load edge refills the shadow and stays pending,
            // so it waits for the following wrap.
            if (wr) begin
                sdiv_d  = cfg_div;
                shigh_d = cfg_high;
                pend_d  = 1'b1;
            end

            rise_d = !clk_q && clk_d;
            fall_d = clk_q && !clk_d;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                p_q     <= '0;
                div_q   <= DIV_RST;
                high_q  <= HIGH_RST;
                sdiv_q  <= DIV_RST;
                shigh_q <= HIGH_RST;
                pend_q  <= 1'b0;
                clk_q   <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                p_q     <= p_d;
                div_q   <= div_d;
                high_q  <= high_d;
                sdiv_q  <= sdiv_d;
                shigh_q <= shigh_d;
                pend_q  <= pend_d;
                clk_q   <= clk_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end

        assign clk_out[i]     = clk_q;
        assign rise_tick[i]   = rise_q;
        assign fall_tick[i]   = fall_q;
        assign cfg_pending[i] = pend_q;
    end

endmodule

// File: tb/tb_multi_counter_clock.sv
module tb_multi_counter_clock;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_div;
    logic [15:0] cfg_high;
    logic [3:0]  ch_en;
    logic [3:0]  clk_out, rise_tick, fall_tick, cfg_pending;
`ifdef CLKDIV_SYNC_EN
    logic        sync_in;
`endif

    int checks = 0;
    int errors = 0;

    multi_counter_clock #(.CHANNELS(4), .DIV_BITS(16), .DEFAULT_DIV(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_div     (cfg_div),
        .cfg_high    (cfg_high),
        .ch_en       (ch_en),
`ifdef CLKDIV_SYNC_EN
        .sync_in     (sync_in),
`endif
        .clk_out     (clk_out),
        .rise_tick   (rise_tick),
        .fall_tick   (fall_tick),
        .cfg_pending (cfg_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        we;
        logic [1:0]  ch;
        logic [15:0] div;
        logic [15:0] high;
        logic [3:0]  en;
        logic [3:0]  e_clk;
        logic [3:0]  e_rise;
        logic [3:0]  e_fall;
        logic [3:0]  e_pend;
    } vec_t;

    vec_t vt[$];

    task automatic add_vec(input logic r, input logic we, input logic [1:0] ch,
                           input logic [15:0] dv, input logic [15:0] hi, input logic [3:0] en,
                           input logic [3:0] ec, input logic [3:0] er, input logic [3:0] ef,
                           input logic [3:0] ep);
        vec_t v;
        v.rst = r; v.we = we; v.ch = ch; v.div = dv; v.high = hi; v.en = en;
        v.e_clk = ec; v.e_rise = er; v.e_fall = ef; v.e_pend = ep;
        vt.push_back(v);
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_cfg(input logic [1:0] ch, input int dv, input int hi);
        cfg_we   = 1'b1;
        cfg_ch   = ch;
        cfg_div  = 16'(dv);
        cfg_high = 16'(hi);
        tick();
        cfg_we   = 1'b0;
    endtask

    // Reference model: each channel is described by its position in the
    // current period plus an active and a shadow setting.
    int m_pos[4], m_div[4], m_high[4], m_sdiv[4], m_shigh[4];
    bit m_pend[4], m_clk[4], m_rise[4], m_fall[4];

    task automatic mdl_step();
        for (int c = 0; c < 4; c++) begin
            if (rst) begin
                m_pos[c] = 0; m_div[c] = 2; m_high[c] = 1; m_sdiv[c] = 2; m_shigh[c] = 1;
                m_pend[c] = 0; m_clk[c] = 0; m_rise[c] = 0; m_fall[c] = 0;
            end else begin
                int  period, hi_time, next_pos;
                bit  level, take;
                period  = (m_div[c] < 2) ? 2 : m_div[c];
                hi_time = (m_high[c] < period) ? m_high[c] : period - 1;
                if (ch_en[c]) begin
                    level    = (m_pos[c] < hi_time);
                    take     = m_pend[c] && (m_pos[c] == period - 1);
                    next_pos = (m_pos[c] + 1) % period;
                end else begin
                    level    = 0;
                    take     = m_pend[c];
                    next_pos = 0;
                end
                m_rise[c] = level && !m_clk[c];
                m_fall[c] = !level && m_clk[c];
                m_clk[c]  = level;
                m_pos[c]  = next_pos;
                if (take) begin
                    m_div[c] = m_sdiv[c]; m_high[c] = m_shigh[c]; m_pend[c] = 0;
                end
                if (cfg_we && int'(cfg_ch) == c) begin
                    m_sdiv[c] = int'(cfg_div); m_shigh[c] = int'(cfg_high); m_pend[c] = 1;
                end
            end
        end
    endtask

    initial begin
        logic [3:0] e_clk, e_rise, e_fall, e_pend;
        int highs, rises;
        rst = 1'b1; cfg_we = 1'b0; cfg_ch = 2'd0; cfg_div = 16'd0; cfg_high = 16'd0;
        ch_en = 4'b0000;
`ifdef CLKDIV_SYNC_EN
        sync_in = 1'b0;
`endif

        // ---------------- table-driven vectors ----------------
        add_vec(1'b1, 1'b0, 2'd0, 16'd0,  16'd0,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add_vec(1'b0, 1'b1, 2'd0, 16'd3,  16'd1,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        add_vec(1'b0, 1'b0, 2'd0, 16'd0,  16'd0,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add_vec(1'b0, 1'b0, 2'd0, 16'd0,  16'd0,  4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        add_vec(1'b0, 1'b0, 2'd0, 16'd0,  16'd0,  4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        add_vec(1'b0, 1'b0, 2'd0, 16'd0,  16'd0,  4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add_vec(1'b0, 1'b0, 2'd0, 16'd0,  16'd0,  4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        add_vec(1'b0, 1'b1, 2'd0, 16'd0,  16'd5,  4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
        add_vec(1'b0, 1'b0, 2'd0, 16'd0,  16'd0,  4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add_vec(1'b0, 1'b0, 2'd0, 16'd0,  16'd0,  4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        add_vec(1'b0, 1'b0, 2'd0, 16'd0,  16'd0,  4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        add_vec(1'b0, 1'b0, 2'd0, 16'd0,  16'd0,  4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        add_vec(1'b0, 1'b0, 2'd0, 16'd0,  16'd0,  4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        add_vec(1'b0, 1'b0, 2'd0, 16'd0,  16'd0,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add_vec(1'b0, 1'b1, 2'd3, 16'd5,  16'd0,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000);
        add_vec(1'b0, 1'b0, 2'd0, 16'd0,  16'd0,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add_vec(1'b0, 1'b0, 2'd0, 16'd0,  16'd0,  4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add_vec(1'b0, 1'b1, 2'd2, 16'd5,  16'd20, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
        add_vec(1'b0, 1'b0, 2'd0, 16'd0,  16'd0,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add_vec(1'b0, 1'b0, 2'd0, 16'd0,  16'd0,  4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000);
        add_vec(1'b0, 1'b0, 2'd0, 16'd0,  16'd0,  4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        add_vec(1'b0, 1'b0, 2'd0, 16'd0,  16'd0,  4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        add_vec(1'b0, 1'b0, 2'd0, 16'd0,  16'd0,  4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        add_vec(1'b0, 1'b0, 2'd0, 16'd0,  16'd0,  4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
        add_vec(1'b0, 1'b0, 2'd0, 16'd0,  16'd0,  4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000);

        for (int k = 0; k < vt.size(); k++) begin
            rst = vt[k].rst; cfg_we = vt[k].we; cfg_ch = vt[k].ch;
            cfg_div = vt[k].div; cfg_high = vt[k].high; ch_en = vt[k].en;
            tick();
            chk($sformatf("vec%0d clk_out", k),     clk_out,     vt[k].e_clk);
            chk($sformatf("vec%0d rise_tick", k),   rise_tick,   vt[k].e_rise);
            chk($sformatf("vec%0d fall_tick", k),   fall_tick,   vt[k].e_fall);
            chk($sformatf("vec%0d cfg_pending", k), cfg_pending, vt[k].e_pend);
        end
        cfg_we = 1'b0; ch_en = 4'b0000;

        // ---------------- div=10 high=5, rewrite to div=4 high=1 at p=3 ----------------
        rst = 1'b1; tick(); rst = 1'b0;
        wr_cfg(2'd0, 10, 5);
        tick();
        chk("reprog loaded while disabled", cfg_pending, 4'b0000);
        ch_en = 4'b0001;
        tick(); tick(); tick();
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd4; cfg_high = 16'd1;
        tick();
        cfg_we = 1'b0;
        chk("reprog write edge clk", clk_out, 4'b0001);
        chk("reprog write edge pend", cfg_pending, 4'b0001);
        for (int k = 4; k <= 9; k++) begin
            tick();
            chk($sformatf("reprog old p%0d clk", k), clk_out, (k < 5) ? 4'b0001 : 4'b0000);
            chk($sformatf("reprog old p%0d pend", k), cfg_pending, (k < 9) ? 4'b0001 : 4'b0000);
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("reprog new c%0d clk", k), clk_out, (k % 4 == 0) ? 4'b0001 : 4'b0000);
        end

        // ---------------- div=12 high=6, drop and restore enable ----------------
        ch_en = 4'b0000; tick();
        wr_cfg(2'd0, 12, 6);
        tick();
        ch_en = 4'b0001;
        tick();
        chk("en first edge rise", rise_tick, 4'b0001);
        tick();
        ch_en = 4'b0000;
        tick();
        chk("drop en clk", clk_out, 4'b0000);
        chk("drop en fall", fall_tick, 4'b0001);
        tick();
        chk("disabled fall clear", fall_tick, 4'b0000);
        ch_en = 4'b0001;
        tick();
        chk("re-enable rise", rise_tick, 4'b0001);
        chk("re-enable clk", clk_out, 4'b0001);
        highs = 0; rises = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (clk_out[0]) highs++;
            if (rise_tick[0]) rises++;
        end
        chk("div12 high cycles", 4'(highs), 4'd6);
        chk("div12 rises per period", 4'(rises), 4'd1);
        chk("div12 rise at period end", rise_tick, 4'b0001);

        // ---------------- four channels, reset mid-period ----------------
        ch_en = 4'b0000; tick();
        wr_cfg(2'd0, 2, 1);
        wr_cfg(2'd1, 3, 1);
        wr_cfg(2'd2, 7, 3);
        wr_cfg(2'd3, 65535, 30000);
        tick();
        chk("multi all loaded", cfg_pending, 4'b0000);
        ch_en = 4'b1111;
        for (int k = 0; k < 10; k++) tick();
        wr_cfg(2'd1, 9, 4);
        chk("multi pending before rst", cfg_pending[1] ? 4'b0010 : 4'b0000, 4'b0010);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst clk_out", clk_out, 4'b0000);
        chk("rst rise", rise_tick, 4'b0000);
        chk("rst fall", fall_tick, 4'b0000);
        chk("rst pending", cfg_pending, 4'b0000);
        tick();
        chk("post rst c0 clk", clk_out, 4'b1111);
        tick();
        chk("post rst c1 clk", clk_out, 4'b0000);
        chk("post rst c1 fall", fall_tick, 4'b1111);
        tick();
        chk("post rst c2 clk", clk_out, 4'b1111);

`ifdef CLKDIV_SYNC_EN
        // ---------------- phase alignment via sync_in ----------------
        ch_en = 4'b0000; tick();
        wr_cfg(2'd0, 8, 4);
        wr_cfg(2'd1, 8, 4);
        tick();
        ch_en = 4'b0001;
        tick(); tick(); tick();
        ch_en = 4'b0011;
        tick(); tick();
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        chk("sync edge clk", clk_out & 4'b0011, 4'b0011);
        for (int k = 0; k < 16; k++) begin
            tick();
            chk($sformatf("sync aligned c%0d", k), clk_out & 4'b0011,
                ((k % 8) < 4) ? 4'b0011 : 4'b0000);
        end
        ch_en = 4'b0000;
`endif

        // ---------------- randomized run against the model ----------------
        rst = 1'b1; cfg_we = 1'b0; ch_en = 4'b0000;
        mdl_step();
        tick();
        rst = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            int idx;
            rst      = ($urandom_range(0, 199) == 0);
            cfg_we   = ($urandom_range(0, 7) == 0);
            cfg_ch   = 2'($urandom_range(0, 3));
            cfg_div  = 16'($urandom_range(0, 12));
            cfg_high = 16'($urandom_range(0, 12));
            if ($urandom_range(0, 15) == 0) begin
                idx = int'($urandom_range(0, 3));
                ch_en[idx] = ~ch_en[idx];
            end
            mdl_step();
            tick();
            for (int c = 0; c < 4; c++) begin
                e_clk[c] = m_clk[c]; e_rise[c] = m_rise[c];
                e_fall[c] = m_fall[c]; e_pend[c] = m_pend[c];
            end
            chk($sformatf("rand%0d clk_out", n),     clk_out,     e_clk);
            chk($sformatf("rand%0d rise_tick", n),   rise_tick,   e_rise);
            chk($sformatf("rand%0d fall_tick", n),   fall_tick,   e_fall);
            chk($sformatf("rand%0d cfg_pending", n), cfg_pending, e_pend);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
